// File: rtl/async_up_counter.sv
// Ripple up counter: a chain of toggle flops, stage 0 clocked by clk and every
// higher stage clocked by the falling edge of the stage below it.
`timescale 1ns / 1ps

module async_up_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  logic [WIDTH-1:0] q_q;

  for (genvar i = 0; i < WIDTH; i++) begin : gen_stage
    logic bit_q;
    logic bit_d;

    always_comb begin
      bit_d = ~bit_q;
    end

    if (i == 0) begin : gen_root
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          bit_q <= 1'b0;
        end else begin
          bit_q <= bit_d;
        end
      end
    end else begin : gen_ripple
      // A 1->0 transition on the stage below is its carry out.
      always_ff @(negedge q_q[i-1] or negedge rst) begin
        if (!rst) begin
          bit_q <= 1'b0;
        end else begin
          bit_q <= bit_d;
        end
      end
    end

    assign q_q[i] = bit_q;
  end

  assign q  = q_q;
  assign tc = &q_q;

endmodule

// File: tb/tb_async_up_counter.sv
// Self-checking bench for async_up_counter at WIDTH 4, 1 and 8, all sharing clk/rst.
`timescale 1ns / 1ps

module tb_async_up_counter;

  logic       clk;
  logic       rst;
  logic [3:0] q4;
  logic       tc4;
  logic [0:0] q1;
  logic       tc1;
  logic [7:0] q8;
  logic       tc8;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  // Reference: number of counted rising edges since the last reset.
  int unsigned cnt     = 0;

  async_up_counter #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .q(q4), .tc(tc4));
  async_up_counter #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .q(q1), .tc(tc1));
  async_up_counter #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .q(q8), .tc(tc8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst_lvl;
    int unsigned edges;
    logic [3:0]  exp_q;
    bit          exp_tc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("model_q4", 32'(q4), 32'(cnt % 16));
    chk("model_tc4", 32'(tc4), 32'((cnt % 16) == 15));
    chk("model_q1", 32'(q1), 32'(cnt % 2));
    chk("model_tc1", 32'(tc1), 32'((cnt % 2) == 1));
    chk("model_q8", 32'(q8), 32'(cnt % 256));
    chk("model_tc8", 32'(tc8), 32'((cnt % 256) == 255));
  endtask

  // One rising edge, then sample after the ripple has settled.
  task automatic tick();
    @(posedge clk);
    if (rst) cnt++;
    #2;
    chk_model();
  endtask

  task automatic assert_reset();
    rst = 1'b0;
    cnt = 0;
    #1;
  endtask

  initial begin
    int tc_hi;
    rst = 1'b0;

    vecs[0] = '{rst_lvl: 1'b0, edges: 0,  exp_q: 4'h0, exp_tc: 1'b0};
    vecs[1] = '{rst_lvl: 1'b0, edges: 2,  exp_q: 4'h0, exp_tc: 1'b0};
    vecs[2] = '{rst_lvl: 1'b1, edges: 1,  exp_q: 4'h1, exp_tc: 1'b0};
    vecs[3] = '{rst_lvl: 1'b1, edges: 1,  exp_q: 4'h2, exp_tc: 1'b0};
    vecs[4] = '{rst_lvl: 1'b1, edges: 3,  exp_q: 4'h5, exp_tc: 1'b0};
    vecs[5] = '{rst_lvl: 1'b0, edges: 0,  exp_q: 4'h0, exp_tc: 1'b0};
    vecs[6] = '{rst_lvl: 1'b0, edges: 1,  exp_q: 4'h0, exp_tc: 1'b0};
    vecs[7] = '{rst_lvl: 1'b1, edges: 10, exp_q: 4'ha, exp_tc: 1'b0};
    vecs[8] = '{rst_lvl: 1'b1, edges: 5,  exp_q: 4'hf, exp_tc: 1'b1};
    vecs[9] = '{rst_lvl: 1'b1, edges: 1,  exp_q: 4'h0, exp_tc: 1'b0};

    #2;
    // Table: reset, count, mid-count reset at 0101, resume, reach 1111, wrap.
    for (int i = 0; i < 10; i++) begin
      rst = vecs[i].rst_lvl;
      if (!rst) cnt = 0;
      #1;
      for (int e = 0; e < int'(vecs[i].edges); e++) tick();
      chk($sformatf("vec%0d_q", i), 32'(q4), 32'(vecs[i].exp_q));
      chk($sformatf("vec%0d_tc", i), 32'(tc4), 32'(vecs[i].exp_tc));
    end

    // Full 4-bit wrap: tc high for exactly one of 16 edges, ending at 0000.
    assert_reset();
    rst = 1'b1;
    tc_hi = 0;
    for (int e = 0; e < 16; e++) begin
      tick();
      if (tc4) tc_hi++;
    end
    chk("wrap4_tc_count", 32'(tc_hi), 32'd1);
    chk("wrap4_q", 32'(q4), 32'h0);
    chk("wrap4_tc_end", 32'(tc4), 32'h0);

    // Release coincident with a rising edge: that edge must not count.
    assert_reset();
    @(posedge clk);
    rst <= 1'b1;
    #2;
    chk("coinc_hold_q", 32'(q4), 32'h0);
    chk("coinc_hold_q8", 32'(q8), 32'h0);
    tick();
    chk("coinc_next_q", 32'(q4), 32'h1);

    // Random run: mostly counting, with occasional mid-cycle reset pulses.
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        assert_reset();
        chk("rand_rst_immediate", 32'(q8), 32'h0);
        chk("rand_rst_tc", 32'(tc4), 32'h0);
        tick();
        rst = 1'b1;
      end else begin
        tick();
      end
    end

    // Full 8-bit wrap: tc8 high for exactly one of 256 edges.
    assert_reset();
    rst = 1'b1;
    tc_hi = 0;
    for (int e = 0; e < 256; e++) begin
      tick();
      if (tc8) tc_hi++;
    end
    chk("wrap8_tc_count", 32'(tc_hi), 32'd1);
    chk("wrap8_q", 32'(q8), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
